// File: rtl/aes_key_schedule_pkg.sv
// rtl/aes_key_schedule_pkg.sv - AES-128 constants, state enum, xtime and S-box table
package aes_pkg;

    localparam int NK = 4;
    localparam int NR = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - start/key command and round-key stream between schedule and cipher core
interface aes_key_schedule_if;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         done;

    modport master (
        output start, key, rk_ready,
        input  busy, rk_valid, rk, rk_idx, done
    );

    modport slave (
        input  start, key, rk_ready,
        output busy, rk_valid, rk, rk_idx, done
    );
endinterface

// File: rtl/aes_key_schedule_sbox.sv
// rtl/aes_key_schedule_sbox.sv - combinational AES S-box byte lookup
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);
    assign o_out = SBOX[i_in];
endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expansion, one round key per stream transfer
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    aes_key_schedule_if.slave ks
);

    state_t       r_state, w_state_nxt;
    logic [127:0] r_rk, w_rk_nxt;
    logic [3:0]   r_rk_idx, w_idx_nxt;
    logic [7:0]   r_rcon, w_rcon_nxt;
    logic         r_done, w_done_nxt;

    logic [31:0]  w_rot, w_sub, w_temp;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [127:0] w_next_key;

    // RotWord on w3, then SubWord through one S-box per byte
    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    for (genvar g = 0; g < NK; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_in  (w_rot[8*g +: 8]),
            .o_out (w_sub[8*g +: 8])
        );
    end

    assign w_temp     = w_sub ^ {r_rcon, 24'h000000};
    assign w_w0       = r_rk[127:96] ^ w_temp;
    assign w_w1       = r_rk[95:64]  ^ w_w0;
    assign w_w2       = r_rk[63:32]  ^ w_w1;
    assign w_w3       = r_rk[31:0]   ^ w_w2;
    assign w_next_key = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rk_nxt    = r_rk;
        w_idx_nxt   = r_rk_idx;
        w_rcon_nxt  = r_rcon;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (ks.start) begin
                    w_state_nxt = EMIT;
                    w_rk_nxt    = ks.key;
                    w_idx_nxt   = 4'd0;
                    w_rcon_nxt  = RCON_INIT;
                end
            end
            EMIT: begin
                if (ks.rk_ready) begin
                    if (r_rk_idx == 4'(NR)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_rk_nxt   = w_next_key;
                        w_idx_nxt  = r_rk_idx + 4'd1;
                        w_rcon_nxt = xtime(r_rcon);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rk     <= '0;
            r_rk_idx <= '0;
            r_rcon   <= RCON_INIT;
            r_done   <= 1'b0;
        end else begin
            r_rk     <= w_rk_nxt;
            r_rk_idx <= w_idx_nxt;
            r_rcon   <= w_rcon_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign ks.busy     = (r_state == EMIT);
    assign ks.rk_valid = (r_state == EMIT);
    assign ks.rk       = r_rk;
    assign ks.rk_idx   = r_rk_idx;
    assign ks.done     = r_done;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed FIPS-197 / zero-key vectors plus stall, restart and reset sequences
module tb_aes_key_schedule;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t vecs[$];
    logic [127:0] got [11];

    aes_key_schedule_if ks_if ();

    aes_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ks_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [127:0] k, input int i, input logic [127:0] r);
        vec_t v;
        v.key = k;
        v.idx = i;
        v.rk  = r;
        vecs.push_back(v);
    endtask

    task automatic compare_table(input logic [127:0] k, input string tag);
        foreach (vecs[i]) begin
            if (vecs[i].key == k)
                check($sformatf("%s_rk%0d", tag, vecs[i].idx), got[vecs[i].idx], vecs[i].rk);
        end
    endtask

    task automatic start_sched(input logic [127:0] k);
        ks_if.start = 1'b1;
        ks_if.key   = k;
        @(posedge clk);
        #1;
        ks_if.start = 1'b0;
        ks_if.key   = ALT_KEY;
    endtask

    // Consume one schedule; entered and left at #1 after a rising edge.
    task automatic capture(input bit rnd, input int inj_a, input int inj_b,
                           output int done_cyc, output int last_hs);
        int           hs;
        bit           prev_stall;
        bit           rdy;
        logic [127:0] prev_rk;
        logic [3:0]   prev_idx;
        hs         = 0;
        done_cyc   = -1;
        last_hs    = -1;
        prev_stall = 1'b0;
        prev_rk    = '0;
        prev_idx   = '0;
        for (int i = 0; i < 11; i++) got[i] = '0;
        for (int n = 1; n <= 400; n++) begin
            if (prev_stall) begin
                check("stall_rk", ks_if.rk, prev_rk);
                check("stall_idx", 128'(ks_if.rk_idx), 128'(prev_idx));
            end
            if (ks_if.done) begin
                done_cyc = n;
                check("done_after_11_hs", 128'(hs), 128'd11);
                check("done_busy", 128'(ks_if.busy), 128'd0);
                check("done_valid", 128'(ks_if.rk_valid), 128'd0);
                break;
            end
            check("valid_until_done", 128'(ks_if.rk_valid), 128'd1);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ks_if.rk_ready = rdy;
            ks_if.start    = (n == inj_a) || (n == inj_b);
            ks_if.key      = ALT_KEY;
            if (ks_if.rk_valid && rdy) begin
                check("hs_idx", 128'(ks_if.rk_idx), 128'(hs));
                if (ks_if.rk_idx <= 4'd10) got[ks_if.rk_idx] = ks_if.rk;
                hs++;
                last_hs = n;
            end
            prev_stall = ks_if.rk_valid && !rdy;
            prev_rk    = ks_if.rk;
            prev_idx   = ks_if.rk_idx;
            @(posedge clk);
            #1;
        end
        ks_if.start    = 1'b0;
        ks_if.rk_ready = 1'b1;
        if (done_cyc < 0) check("done_timeout", 128'd0, 128'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  128'(ks_if.busy), 128'd0);
        check({tag, "_valid"}, 128'(ks_if.rk_valid), 128'd0);
        check({tag, "_rk"},    ks_if.rk, 128'd0);
        check({tag, "_idx"},   128'(ks_if.rk_idx), 128'd0);
        check({tag, "_done"},  128'(ks_if.done), 128'd0);
    endtask

    initial begin
        int  dc;
        int  lh;
        bit  found;
        checks   = 0;
        failures = 0;

        add_vec(FIPS_KEY, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
        add_vec(FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605);
        add_vec(FIPS_KEY, 2,  128'hf2c295f27a96b9435935807a7359f67f);
        add_vec(FIPS_KEY, 3,  128'h3d80477d4716fe3e1e237e446d7a883b);
        add_vec(FIPS_KEY, 4,  128'hef44a541a8525b7fb671253bdb0bad00);
        add_vec(FIPS_KEY, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc);
        add_vec(FIPS_KEY, 6,  128'h6d88a37a110b3efddbf98641ca0093fd);
        add_vec(FIPS_KEY, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
        add_vec(FIPS_KEY, 8,  128'head27321b58dbad2312bf5607f8d292f);
        add_vec(FIPS_KEY, 9,  128'hac7766f319fadc2128d12941575c006e);
        add_vec(FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        add_vec(ZERO_KEY, 0,  128'h00000000000000000000000000000000);
        add_vec(ZERO_KEY, 1,  128'h62636363626363636263636362636363);
        add_vec(ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        reset          = 1'b1;
        ks_if.start    = 1'b0;
        ks_if.key      = '0;
        ks_if.rk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // FIPS key, consumer always ready
        start_sched(FIPS_KEY);
        capture(1'b0, 0, 0, dc, lh);
        check("fips_done_cycle", 128'(dc), 128'd12);
        check("fips_last_hs", 128'(lh), 128'd11);
        compare_table(FIPS_KEY, "fips");

        // start in the done cycle is accepted
        start_sched(ZERO_KEY);
        capture(1'b0, 0, 0, dc, lh);
        check("zero_done_cycle", 128'(dc), 128'd12);
        compare_table(ZERO_KEY, "zero");

        // random back-pressure
        @(posedge clk);
        #1;
        start_sched(FIPS_KEY);
        capture(1'b1, 0, 0, dc, lh);
        check("rnd_done_after_last_hs", 128'(dc), 128'(lh + 1));
        compare_table(FIPS_KEY, "rnd");

        // start while busy, including on the final transfer, is ignored
        @(posedge clk);
        #1;
        start_sched(FIPS_KEY);
        capture(1'b0, 4, 11, dc, lh);
        check("inj_done_cycle", 128'(dc), 128'd12);
        compare_table(FIPS_KEY, "inj");
        @(posedge clk);
        #1;
        check("inj_idle_after_done", 128'(ks_if.busy), 128'd0);

        // reset mid-schedule at rk_idx 5
        start_sched(FIPS_KEY);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ks_if.rk_valid && ks_if.rk_idx == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("reach_idx5", 128'(found), 128'd1);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            check("post_reset_done", 128'(ks_if.done), 128'd0);
            check("post_reset_busy", 128'(ks_if.busy), 128'd0);
            @(posedge clk);
            #1;
        end
        start_sched(ZERO_KEY);
        capture(1'b0, 0, 0, dc, lh);
        check("restart_done_cycle", 128'(dc), 128'd12);
        compare_table(ZERO_KEY, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
